count_result_serializer: RTL and testbench

//   Downstream of the photon-counter/timestamp block: accepts its 64-bit result words (fifo_data/fifo_data_ready),

---
 rtl/count_result_serializer.sv | 82 ++++++++
 tb/tb_count_result_serializer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/count_result_serializer.sv
// count_result_serializer: buffers 64-bit counter results and streams them out as 16-bit slices
module count_result_serializer #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_rst,
  input  logic [63:0]       in_data,
  input  logic              in_valid,
  output logic              in_full,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W+2:0] out_level,
  output logic              overflow
);
  logic [63:0]       mem [DEPTH];
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [63:0]       hold_q, hold_d;
  logic [1:0]        phase_q, phase_d;
  logic              hold_valid_q, hold_valid_d;
  logic              overflow_q, overflow_d;
  logic              last_acc, pop, push;
  logic [2:0]        slices_left;
  // next state: hold reloads when idle or when its last slice leaves; a pop frees room for a push at full
  always_comb begin
    last_acc     = hold_valid_q && phase_q == 2'd3 && out_ready;
    pop          = (!hold_valid_q || last_acc) && count_q != '0;
    push         = in_valid && (count_q != (ADDR_W+1)'(DEPTH) || pop);
    count_d      = count_q + {ADDR_W'(0), push} - {ADDR_W'(0), pop};
    wr_ptr_d     = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    hold_d       = pop ? mem[rd_ptr_q] : hold_q;
    phase_d      = pop ? 2'd0 : (hold_valid_q && out_ready) ? phase_q + 2'd1 : phase_q;
    hold_valid_d = pop ? 1'b1 : last_acc ? 1'b0 : hold_valid_q;
    overflow_d   = overflow_q || (in_valid && !push);
  end
  // state registers; fifo_rst flushes synchronously and overrides everything else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      hold_q       <= '0;
      phase_q      <= '0;
      hold_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (fifo_rst) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      hold_q       <= '0;
      phase_q      <= '0;
      hold_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      hold_q       <= hold_d;
      phase_q      <= phase_d;
      hold_valid_q <= hold_valid_d;
      overflow_q   <= overflow_d;
    end
  end
  // buffer storage; contents need no reset since pointers and count define validity
  always_ff @(posedge clk) begin
    if (push && !fifo_rst) mem[wr_ptr_q] <= in_data;
  end
  // outputs decoded from registered state only
  always_comb begin
    slices_left = hold_valid_q ? 3'd4 - {1'b0, phase_q} : 3'd0;
    out_valid   = hold_valid_q;
    out_data    = hold_q[{phase_q, 4'b0000} +: 16];
    in_full     = count_q >= (ADDR_W+1)'(DEPTH - FULL_MARGIN);
    out_level   = {count_q, 2'b00} + {ADDR_W'(0), slices_left};
    overflow    = overflow_q;
  end
endmodule

// File: tb/tb_count_result_serializer.sv
// tb_count_result_serializer: directed self-checking bench for count_result_serializer
module tb_count_result_serializer;
  logic        clk = 1'b0;
  logic        rst_n, fifo_rst, in_valid, out_ready;
  logic [63:0] in_data;
  logic        in_full, out_valid, overflow;
  logic [15:0] out_data;
  logic [6:0]  out_level;
  int pass_cnt = 0;
  int total_cnt = 0;

  count_result_serializer dut (
    .clk(clk), .rst_n(rst_n), .fifo_rst(fifo_rst), .in_data(in_data), .in_valid(in_valid),
    .in_full(in_full), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_level(out_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {v | 16'h3000, v | 16'h2000, v | 16'h1000, v};
  endfunction

  task automatic push_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_data = mk(base + i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; fifo_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_full !== 1'b0) $display("FAIL reset in_full got %b want 0", in_full); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset overflow got %b want 0", overflow); else pass_cnt++;
    total_cnt++; if (out_level !== 7'd0) $display("FAIL reset out_level got %0d want 0", out_level); else pass_cnt++;
    total_cnt++; if (out_data !== 16'h0) $display("FAIL reset out_data got %h want 0", out_data); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    logic [15:0] exp [4];
    exp[0] = 16'h0201; exp[1] = 16'h0403; exp[2] = 16'h0605; exp[3] = 16'h0807;
    out_ready = 1'b1;
    in_data = 64'h0807060504030201;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL single no_bypass out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_level !== 7'd4) $display("FAIL single level_buffered got %0d want 4", out_level); else pass_cnt++;
    tick();
    for (int s = 0; s < 4; s++) begin
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL single valid[%0d] got %b want 1", s, out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== exp[s]) $display("FAIL single data[%0d] got %h want %h", s, out_data, exp[s]); else pass_cnt++;
      total_cnt++; if (out_level !== 7'(4 - s)) $display("FAIL single level[%0d] got %0d want %0d", s, out_level, 4 - s); else pass_cnt++;
      tick();
    end
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL single end_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_level !== 7'd0) $display("FAIL single end_level got %0d want 0", out_level); else pass_cnt++;
  endtask

  task automatic test_overflow;
    int cnt;
    out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      in_data = 64'(i);
      in_valid = 1'b1;
      tick();
      cnt = (i == 1) ? 1 : ((i - 1 > 16) ? 16 : i - 1);
      total_cnt++;
      if (in_full !== (cnt >= 14)) $display("FAIL ovf in_full after push %0d got %b want %b", i, in_full, cnt >= 14); else pass_cnt++;
    end
    in_valid = 1'b0;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf overflow got %b want 1", overflow); else pass_cnt++;
    total_cnt++; if (out_level !== 7'd68) $display("FAIL ovf out_level got %0d want 68", out_level); else pass_cnt++;
    out_ready = 1'b1;
    for (int w = 1; w <= 17; w++) begin
      for (int s = 0; s < 4; s++) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== ((s == 0) ? 16'(w) : 16'h0))
          $display("FAIL ovf drain w%0d s%0d got v=%b d=%h want v=1 d=%h", w, s, out_valid, out_data, (s == 0) ? 16'(w) : 16'h0);
        else pass_cnt++;
        tick();
      end
    end
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL ovf drained out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf sticky got %b want 1", overflow); else pass_cnt++;
    fifo_rst = 1'b1;
    tick();
    fifo_rst = 1'b0;
  endtask

  task automatic test_toggle;
    int pushed = 0;
    int got = 0;
    logic stalled = 1'b0;
    logic [15:0] prev = '0;
    logic [63:0] w;
    logic [15:0] v;
    for (int cyc = 0; cyc < 3000 && got < 128; cyc++) begin
      out_ready = cyc[0];
      in_valid = (cyc % 3 == 0) && pushed < 32 && !in_full;
      v = 16'(pushed * 4) + 16'hA000;
      w = {v + 16'd3, v + 16'd2, v + 16'd1, v};
      in_data = w;
      if (in_valid) pushed++;
      if (stalled) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== prev) $display("FAIL toggle stable got v=%b d=%h want v=1 d=%h", out_valid, out_data, prev); else pass_cnt++;
      end
      if (out_valid && out_ready) begin
        total_cnt++;
        if (out_data !== 16'hA000 + 16'(got)) $display("FAIL toggle slice %0d got %h want %h", got, out_data, 16'hA000 + 16'(got)); else pass_cnt++;
        got++;
      end
      stalled = out_valid && !out_ready;
      prev = out_data;
      tick();
    end
    in_valid = 1'b0;
    total_cnt++; if (got !== 128) $display("FAIL toggle slice_count got %0d want 128", got); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL toggle overflow got %b want 0", overflow); else pass_cnt++;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_full_pop;
    logic [63:0] w;
    out_ready = 1'b0;
    push_words(17, 1);
    total_cnt++; if (out_level !== 7'd68) $display("FAIL fullpop level got %0d want 68", out_level); else pass_cnt++;
    total_cnt++; if (in_full !== 1'b1) $display("FAIL fullpop in_full got %b want 1", in_full); else pass_cnt++;
    out_ready = 1'b1;
    repeat (3) tick();
    w = mk(1);
    total_cnt++; if (out_data !== w[63:48]) $display("FAIL fullpop phase3 got %h want %h", out_data, w[63:48]); else pass_cnt++;
    in_data = mk(18);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL fullpop overflow got %b want 0", overflow); else pass_cnt++;
    total_cnt++; if (out_level !== 7'd68) $display("FAIL fullpop level_after got %0d want 68", out_level); else pass_cnt++;
    for (int n = 2; n <= 18; n++) begin
      w = mk(n);
      for (int s = 0; s < 4; s++) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== w[16*s +: 16])
          $display("FAIL fullpop drain w%0d s%0d got v=%b d=%h want v=1 d=%h", n, s, out_valid, out_data, w[16*s +: 16]);
        else pass_cnt++;
        tick();
      end
    end
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL fullpop drained out_valid got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    push_words(20, 40);
    total_cnt++; if (overflow !== 1'b1 || in_full !== 1'b1) $display("FAIL areset pre got ovf=%b full=%b want 1 1", overflow, in_full); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL areset out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_full !== 1'b0) $display("FAIL areset in_full got %b want 0", in_full); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL areset overflow got %b want 0", overflow); else pass_cnt++;
    total_cnt++; if (out_level !== 7'd0) $display("FAIL areset out_level got %0d want 0", out_level); else pass_cnt++;
    #2 rst_n = 1'b1;
    tick();
    test_single();
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    push_words(20, 60);
    out_ready = 1'b1;
    repeat (32) tick();
    out_ready = 1'b0;
    total_cnt++; if (out_level !== 7'd36) $display("FAIL flush half level got %0d want 36", out_level); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL flush pre overflow got %b want 1", overflow); else pass_cnt++;
    fifo_rst = 1'b1;
    in_valid = 1'b1;
    in_data = mk(99);
    tick();
    fifo_rst = 1'b0;
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_level !== 7'd0) $display("FAIL flush out_level got %0d want 0", out_level); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL flush overflow got %b want 0", overflow); else pass_cnt++;
    total_cnt++; if (in_full !== 1'b0) $display("FAIL flush in_full got %b want 0", in_full); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0 || out_level !== 7'd0) $display("FAIL flush discard got v=%b lvl=%0d want 0 0", out_valid, out_level); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_toggle();
    test_full_pop();
    test_async_reset();
    test_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
